ps2_key_encoder_tx: RTL and testbench

//  Inverse of the keyboard scan-code-to-ASCII path. Takes an ASCII character and looks up its
//  PS/2 Set-2 make code. Emits the keystroke as a PS/2 device-to-host sequence: make, F0, make.

---
 rtl/ps2_key_encoder_tx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_key_encoder_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder_tx.sv
// ---------------------------------------------------------------------------
// ps2_key_encoder_tx
// Keyboard emulator: turns an ASCII character into its PS/2 Set-2 make code
// and plays the keystroke out as three device-to-host frames (make, F0, make).
// Used for loopback testing of a PS/2 receive chain and for scripted input.
//
// Parameters
//   CLK_DIV  clk cycles per PS/2 clock half-period
//   GAP_CYC  clk cycles of idle lines after each frame's stop bit
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_char_in     ASCII character to send
//   i_char_valid  request, taken on a clock edge where it is high and o_ready=1
//   o_ready       1 = idle, can accept a character
//   o_bad_char    one-cycle pulse: the accepted character has no scan code
//   o_ps2_clk     PS/2 clock line (idle 1)
//   o_ps2_data    PS/2 data line (idle 1)
// ---------------------------------------------------------------------------
module ps2_key_encoder_tx #(
    parameter int CLK_DIV = 2500,
    parameter int GAP_CYC = 5000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_char_in,
    input  logic       i_char_valid,
    output logic       o_ready,
    output logic       o_bad_char,
    output logic       o_ps2_clk,
    output logic       o_ps2_data
);

    // One counter serves both half-periods and the inter-frame gap.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BIT_HI = 3'd2,
        S_BIT_LO = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    // Odd parity bit: makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Serial frame, LSB first: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] build_frame(input logic [7:0] b);
        return {1'b1, odd_parity(b), b, 1'b0};
    endfunction

    // ASCII to Set-2 make code; bit 8 flags a character that has a code.
    function automatic logic [8:0] encode_char(input logic [7:0] c);
        logic [8:0] r;
        case (c)
            8'h30:   r = {1'b1, 8'h45};  // '0'
            8'h31:   r = {1'b1, 8'h16};  // '1'
            8'h32:   r = {1'b1, 8'h1E};  // '2'
            8'h33:   r = {1'b1, 8'h26};  // '3'
            8'h34:   r = {1'b1, 8'h25};  // '4'
            8'h35:   r = {1'b1, 8'h2E};  // '5'
            8'h36:   r = {1'b1, 8'h36};  // '6'
            8'h37:   r = {1'b1, 8'h3D};  // '7'
            8'h38:   r = {1'b1, 8'h3E};  // '8'
            8'h39:   r = {1'b1, 8'h46};  // '9'
            8'h2B:   r = {1'b1, 8'h55};  // '+'
            8'h2A:   r = {1'b1, 8'h7C};  // '*'
            8'h3C:   r = {1'b1, 8'h41};  // '<'
            8'h3E:   r = {1'b1, 8'h49};  // '>'
            8'h3D:   r = {1'b1, 8'h5A};  // '='
            8'h45:   r = {1'b1, 8'h76};  // 'E'
            default: r = {1'b0, 8'h00};
        endcase
        return r;
    endfunction

    logic [8:0] w_enc;
    assign w_enc = encode_char(i_char_in);

    state_t           r_state;
    logic [7:0]       r_code;
    logic [10:0]      r_frame;
    logic [3:0]       r_bit;
    logic [1:0]       r_frame_idx;
    logic [CNT_W-1:0] r_cnt;

    // Keystroke sequencer. The line outputs are registered from the current
    // state, so they trail the state by one cycle; the first start bit thus
    // appears two edges after the accept edge, and the LOAD cycle plus the
    // GAP cycles give GAP_CYC+1 idle cycles between consecutive frames.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_code      <= 8'h00;
            r_frame     <= 11'h7FF;
            r_bit       <= 4'd0;
            r_frame_idx <= 2'd0;
            r_cnt       <= CNT_ZERO;
            o_ready     <= 1'b1;
            o_bad_char  <= 1'b0;
            o_ps2_clk   <= 1'b1;
            o_ps2_data  <= 1'b1;
        end else begin
            o_bad_char <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_ps2_clk  <= 1'b1;
                    o_ps2_data <= 1'b1;
                    o_ready    <= 1'b1;
                    if (i_char_valid) begin
                        if (w_enc[8]) begin
                            r_code      <= w_enc[7:0];
                            r_frame_idx <= 2'd0;
                            o_ready     <= 1'b0;
                            r_state     <= S_LOAD;
                        end else begin
                            o_bad_char <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    o_ps2_clk  <= 1'b1;
                    o_ps2_data <= 1'b1;
                    r_frame    <= build_frame((r_frame_idx == 2'd1) ? 8'hF0 : r_code);
                    r_bit      <= 4'd0;
                    r_cnt      <= HALF_LOAD;
                    r_state    <= S_BIT_HI;
                end
                S_BIT_HI: begin
                    // Data may only change while the clock line is high.
                    o_ps2_clk  <= 1'b1;
                    o_ps2_data <= r_frame[r_bit];
                    if (r_cnt == CNT_ZERO) begin
                        r_cnt   <= HALF_LOAD;
                        r_state <= S_BIT_LO;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_BIT_LO: begin
                    o_ps2_clk <= 1'b0;
                    if (r_cnt == CNT_ZERO) begin
                        if (r_bit == 4'd10) begin
                            r_cnt   <= GAP_LOAD;
                            r_state <= S_GAP;
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_cnt   <= HALF_LOAD;
                            r_state <= S_BIT_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_GAP: begin
                    o_ps2_clk  <= 1'b1;
                    o_ps2_data <= 1'b1;
                    if (r_cnt == CNT_ZERO) begin
                        if (r_frame_idx == 2'd2) begin
                            o_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_idx <= r_frame_idx + 2'd1;
                            r_state     <= S_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    o_ready    <= 1'b1;
                    o_ps2_clk  <= 1'b1;
                    o_ps2_data <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_encoder_tx
// Directed bench for ps2_key_encoder_tx with CLK_DIV=4, GAP_CYC=8
// (97 cycles per frame, 291 per keystroke). A receiver model samples
// ps2_data on every falling ps2_clk and collects frames; a line monitor
// measures idle runs before each start bit and counts bad_char cycles.
// ---------------------------------------------------------------------------
module tb_ps2_key_encoder_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 8;
    localparam int KEY_CYC = 3 * (1 + 22 * CLK_DIV + GAP_CYC);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       ready, bad_char, ps2_clk, ps2_data;

    ps2_key_encoder_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_char_in    (char_in),
        .i_char_valid (char_valid),
        .o_ready      (ready),
        .o_bad_char   (bad_char),
        .o_ps2_clk    (ps2_clk),
        .o_ps2_data   (ps2_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    // Receiver model: host samples data on the falling clock edge.
    logic [10:0] rx_sr = 11'h000;
    int          rx_bits = 0;
    int          rx_err = 0;
    int          rx_q[$];
    int          rx_fr[$];

    initial begin
        forever begin
            @(negedge ps2_clk or posedge reset);
            if (reset) begin
                rx_bits = 0;
            end else begin
                rx_sr = {ps2_data, rx_sr[10:1]};
                rx_bits++;
                if (rx_bits == 11) begin
                    rx_bits = 0;
                    rx_fr.push_back(int'(rx_sr));
                    rx_q.push_back(int'(rx_sr[8:1]));
                    if (rx_sr[0] !== 1'b0 || rx_sr[10] !== 1'b1 || (^rx_sr[9:1]) !== 1'b1)
                        rx_err++;
                end
            end
        end
    end

    // Line monitor: idle run length preceding each start bit, bad_char cycles.
    int idle_run = 0;
    int gaps[$];
    int bad_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bad_char === 1'b1) bad_cnt++;
            if (ps2_clk === 1'b1 && ps2_data === 1'b1) begin
                idle_run++;
            end else begin
                if (ps2_clk === 1'b1 && ps2_data === 1'b0 && idle_run > 0)
                    gaps.push_back(idle_run);
                idle_run = 0;
            end
        end
    end

    function automatic int q_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : -1;
    endfunction

    function automatic int fr_at(input int i);
        return (i < rx_fr.size()) ? rx_fr[i] : -1;
    endfunction

    function automatic int gap_at(input int i);
        return (i < gaps.size()) ? gaps[i] : -1;
    endfunction

    // Present a character for one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] c, output int t_acc);
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1 t_acc = cyc;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    // Wait (bounded) for ready; reports offsets of ready and first data=0 from t_acc.
    task automatic wait_ready(input int t_acc, output int t_rdy, output int t_start);
        t_start = -1;
        t_rdy   = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (t_start < 0 && ps2_data === 1'b0) t_start = cyc - t_acc;
            if (ready === 1'b1) begin
                t_rdy = cyc - t_acc;
                break;
            end
        end
        if (t_rdy < 0) check_val("ready_timeout", 0, 1);
    endtask

    task automatic check_key(input string tag, input int code);
        check_val({tag, "_nbytes"}, rx_q.size(), 3);
        check_val({tag, "_b0"}, q_at(0), code);
        check_val({tag, "_b1"}, q_at(1), 32'hF0);
        check_val({tag, "_b2"}, q_at(2), code);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t_rdy, t_start, b0, viol, t_up, t2;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", int'(ready), 1);
        check_val("rst_bad", int'(bad_char), 0);
        check_val("rst_clk", int'(ps2_clk), 1);
        check_val("rst_data", int'(ps2_data), 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1: '5' -> 2E F0 2E, frame bits hand-built (stop,parity,data,start)
        rx_q.delete(); rx_fr.delete();
        send(8'h35, t);
        check_val("t1_ready_low", int'(ready), 0);
        wait_ready(t, t_rdy, t_start);
        check_val("t1_start_ofs", t_start, 2);
        check_val("t1_ready_ofs", t_rdy, KEY_CYC);
        check_key("t1", 32'h2E);
        check_val("t1_frame0", fr_at(0), 32'h65C);
        check_val("t1_frame1", fr_at(1), 32'h7E0);
        check_val("t1_frame2", fr_at(2), 32'h65C);

        // 2: 'E' -> 76 F0 76, parity 0 on 76
        rx_q.delete(); rx_fr.delete();
        send(8'h45, t);
        wait_ready(t, t_rdy, t_start);
        check_key("t2", 32'h76);
        check_val("t2_frame0", fr_at(0), 32'h4EC);
        check_val("t2_rx_err", rx_err, 0);

        // 3: 'A' has no code -> one bad_char cycle, lines untouched
        rx_q.delete(); rx_fr.delete();
        b0 = bad_cnt;
        send(8'h41, t);
        check_val("t3_bad_pulse", int'(bad_char), 1);
        check_val("t3_ready", int'(ready), 1);
        viol = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0) check_val("t3_bad_end", int'(bad_char), 0);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || ready !== 1'b1) viol++;
        end
        check_val("t3_idle_viol", viol, 0);
        check_val("t3_bad_cycles", bad_cnt - b0, 1);
        check_val("t3_nbytes", rx_q.size(), 0);

        // 4: '1' then '9' pulsed at +10 and +150 while busy -> ignored
        rx_q.delete(); rx_fr.delete();
        b0 = bad_cnt;
        send(8'h31, t);
        t_rdy = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc - t == 10 || cyc - t == 150) begin
                char_in    = 8'h39;
                char_valid = 1'b1;
            end else begin
                char_valid = 1'b0;
            end
            if (ready === 1'b1) begin
                t_rdy = cyc - t;
                break;
            end
        end
        char_valid = 1'b0;
        check_val("t4_ready_ofs", t_rdy, KEY_CYC);
        repeat (5) @(negedge clk);
        check_key("t4", 32'h16);
        check_val("t4_bad_cycles", bad_cnt - b0, 0);

        // 5: reset during 2nd frame bit 4 (its low half), then '0'
        rx_q.delete(); rx_fr.delete();
        send(8'h37, t);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cyc - t >= 136) break;
        end
        check_val("t5_pre_clk", int'(ps2_clk), 0);
        check_val("t5_pre_data", int'(ps2_data), 0);
        check_val("t5_pre_byte", q_at(0), 32'h3D);
        #2 reset = 1'b1;
        #1;
        check_val("t5_rst_clk", int'(ps2_clk), 1);
        check_val("t5_rst_data", int'(ps2_data), 1);
        check_val("t5_rst_ready", int'(ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_q.delete(); rx_fr.delete();
        send(8'h30, t);
        wait_ready(t, t_rdy, t_start);
        check_val("t5_ready_ofs", t_rdy, KEY_CYC);
        check_key("t5", 32'h45);

        // 6: char_valid held: '3' then '=' back to back
        rx_q.delete(); rx_fr.delete(); gaps.delete();
        @(negedge clk);
        char_in    = 8'h33;
        char_valid = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        @(negedge clk);
        char_in = 8'h3D;
        t_up = -1;
        t2   = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ready === 1'b1 && t_up < 0) t_up = cyc - t;
            if (t_up >= 0 && ready === 1'b0) begin
                t2 = cyc - t;
                break;
            end
        end
        char_valid = 1'b0;
        check_val("t6_ready_up", t_up, KEY_CYC);
        check_val("t6_second_acc", t2, KEY_CYC + 1);
        wait_ready(t + t2, t_rdy, t_start);
        check_val("t6_ready_ofs", t_rdy, KEY_CYC);
        check_val("t6_nbytes", rx_q.size(), 6);
        check_val("t6_b0", q_at(0), 32'h26);
        check_val("t6_b1", q_at(1), 32'hF0);
        check_val("t6_b2", q_at(2), 32'h26);
        check_val("t6_b3", q_at(3), 32'h5A);
        check_val("t6_b4", q_at(4), 32'hF0);
        check_val("t6_b5", q_at(5), 32'h5A);
        // Within a keystroke frames are GAP_CYC+1 idle cycles apart; the
        // keystroke boundary also carries the one IDLE cycle where ready=1.
        check_val("t6_gaps", gaps.size(), 6);
        check_val("t6_gap1", gap_at(1), GAP_CYC + 1);
        check_val("t6_gap2", gap_at(2), GAP_CYC + 1);
        check_val("t6_gap3", gap_at(3), GAP_CYC + 2);
        check_val("t6_gap4", gap_at(4), GAP_CYC + 1);
        check_val("t6_gap5", gap_at(5), GAP_CYC + 1);
        check_val("rx_err_total", rx_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
